// File: rtl/hash_pkg.sv
// Shared types and default widths for the SHA-1 block core and its scheduler.
package hash_pkg;

  localparam int HASH_ADDR_W = 11;
  localparam int HASH_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request above last_id, with wrap.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last_id,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id
);

  // Scan from last_id+1 upward; the first set bit wins
  always_comb begin
    logic            found_s;
    logic [ID_W-1:0] idx_s;
    gnt     = '0;
    gnt_id  = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = ID_W'((int'(last_id) + k) % NREQ);
      if (en && !found_s && req[idx_s]) begin
        found_s    = 1'b1;
        gnt[idx_s] = 1'b1;
        gnt_id     = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/hash_scheduler.sv
// Shares one SHA-1 hash_block core between NREQ requesters: round-robin grant,
// one H_int per 512-bit block, per-block timeout, per-requester completion pulse.
module hash_scheduler
  import hash_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = HASH_ADDR_W,
  parameter int CNT_W  = HASH_CNT_W,
  parameter int TMO    = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_base,
  input  logic [NREQ*CNT_W-1:0]    req_nblk,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_done,
  output logic                     rsp_err,
  output logic                     H_int,
  output logic [ADDR_W-1:0]        index,
  input  logic                     H_done,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  cur_id
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int TMO_W = $clog2(TMO + 1);

  sched_state_t      state_r, state_nxt_s;
  logic [ADDR_W-1:0] base_r, base_nxt_s, addr_nxt_s;
  logic [CNT_W-1:0]  nblk_r, nblk_nxt_s, blk_r, blk_nxt_s;
  logic [TMO_W-1:0]  tmo_r, tmo_nxt_s;
  logic              err_r, err_nxt_s;
  logic [ID_W-1:0]   id_r, id_nxt_s, last_r, last_nxt_s, gnt_id_s;
  logic [NREQ-1:0]   gnt_s;
  logic              h_int_r, rsp_err_r, busy_r;
  logic [ADDR_W-1:0] index_r;
  logic [NREQ-1:0]   rsp_done_r;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req     (req_valid),
    .last_id (last_r),
    .en      (state_r == IDLE),
    .gnt     (gnt_s),
    .gnt_id  (gnt_id_s)
  );

  // Next-state, job-register and accept-pulse logic
  always_comb begin
    state_nxt_s = state_r;
    base_nxt_s  = base_r;
    nblk_nxt_s  = nblk_r;
    blk_nxt_s   = blk_r;
    tmo_nxt_s   = tmo_r;
    err_nxt_s   = err_r;
    id_nxt_s    = id_r;
    last_nxt_s  = last_r;
    req_ready   = '0;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          id_nxt_s    = gnt_id_s;
          base_nxt_s  = req_base[int'(gnt_id_s)*ADDR_W +: ADDR_W];
          nblk_nxt_s  = req_nblk[int'(gnt_id_s)*CNT_W +: CNT_W];
          blk_nxt_s   = '0;
          req_ready   = gnt_s;
          state_nxt_s = (nblk_nxt_s == '0) ? RESP : START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        tmo_nxt_s   = '0;
        state_nxt_s = WAIT;
      end
      WAIT: begin
        // A done arriving on the timeout cycle still counts as success
        if (H_done) begin
          blk_nxt_s   = blk_r + CNT_W'(1);
          state_nxt_s = (blk_r + CNT_W'(1) == nblk_r) ? RESP : START;
        end else if (tmo_r == TMO_W'(TMO - 1)) begin
          err_nxt_s   = 1'b1;
          state_nxt_s = RESP;
        end else begin
          tmo_nxt_s = tmo_r + TMO_W'(1);
        end
      end
      RESP: begin
        last_nxt_s  = id_r;
        err_nxt_s   = 1'b0;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    addr_nxt_s = base_nxt_s + ADDR_W'(blk_nxt_s);
  end

  // State, job registers and state-aligned registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      base_r     <= '0;
      nblk_r     <= '0;
      blk_r      <= '0;
      tmo_r      <= '0;
      err_r      <= 1'b0;
      id_r       <= '0;
      last_r     <= ID_W'(NREQ - 1);
      h_int_r    <= 1'b0;
      index_r    <= '0;
      rsp_done_r <= '0;
      rsp_err_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      base_r     <= base_nxt_s;
      nblk_r     <= nblk_nxt_s;
      blk_r      <= blk_nxt_s;
      tmo_r      <= tmo_nxt_s;
      err_r      <= err_nxt_s;
      id_r       <= id_nxt_s;
      last_r     <= last_nxt_s;
      h_int_r    <= (state_nxt_s == START);
      index_r    <= (state_nxt_s == START) ? addr_nxt_s : index_r;
      rsp_done_r <= (state_nxt_s == RESP) ? (NREQ'(1) << id_nxt_s) : '0;
      rsp_err_r  <= (state_nxt_s == RESP) & err_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
    end
  end

  assign H_int    = h_int_r;
  assign index    = index_r;
  assign rsp_done = rsp_done_r;
  assign rsp_err  = rsp_err_r;
  assign busy     = busy_r;
  assign cur_id   = id_r;

endmodule
